// File: rtl/pipe_regs_if.sv
// Bundle of hazard controls, stage inputs and registered stage contents
// between the pipeline control logic and the pipe_regs block.
interface pipe_regs_if;
  localparam int unsigned PC_W = 64;
  localparam int unsigned D_W  = 148;
  localparam int unsigned E_W  = 224;
  localparam int unsigned M_W  = 145;
  localparam int unsigned W_W  = 144;
  localparam int unsigned CC_W = 3;
  localparam int unsigned CNT_W = 32;

  logic              F_stall;
  logic              D_stall;
  logic              D_bubble;
  logic              E_bubble;
  logic              M_bubble;
  logic              W_stall;
  logic              set_cc;
  logic [CC_W-1:0]   cc_in;
  logic [PC_W-1:0]   f_predPC;
  logic [D_W-1:0]    d_in;
  logic [E_W-1:0]    e_in;
  logic [M_W-1:0]    m_in;
  logic [W_W-1:0]    w_in;

  logic [PC_W-1:0]   F_predPC;
  logic [D_W-1:0]    D_out;
  logic [E_W-1:0]    E_out;
  logic [M_W-1:0]    M_out;
  logic [W_W-1:0]    W_out;
  logic [CC_W-1:0]   cc;
  logic              ctrl_err;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           set_cc, cc_in, f_predPC, d_in, e_in, m_in, w_in,
    input  F_predPC, D_out, E_out, M_out, W_out, cc, ctrl_err,
           cycle_cnt, retire_cnt
  );

  modport slave (
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
           set_cc, cc_in, f_predPC, d_in, e_in, m_in, w_in,
    output F_predPC, D_out, E_out, M_out, W_out, cc, ctrl_err,
           cycle_cnt, retire_cnt
  );
endinterface

// File: rtl/pipe_regs.sv
// Five-stage pipeline registers with stall/bubble control, condition codes,
// halt freeze and performance counters.
module pipe_regs (
  input logic       clk,
  input logic       rst,
  pipe_regs_if.slave bus
);
  localparam int unsigned PC_W  = 64;
  localparam int unsigned D_W   = 148;
  localparam int unsigned E_W   = 224;
  localparam int unsigned M_W   = 145;
  localparam int unsigned W_W   = 144;
  localparam int unsigned CC_W  = 3;
  localparam int unsigned CNT_W = 32;

  localparam logic [3:0] STAT_AOK  = 4'h1;
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] RNONE     = 4'hF;
  localparam logic [CC_W-1:0] CC_RESET = 3'b100;

  // E payload has 4 spare bits below srcB; they load through and reset to 0.
  localparam logic [D_W-1:0] D_BUBBLE = {STAT_AOK, ICODE_NOP, 4'h0, RNONE, RNONE,
                                         64'h0, 64'h0};
  localparam logic [E_W-1:0] E_BUBBLE = {STAT_AOK, ICODE_NOP, 4'h0, 64'h0, 64'h0,
                                         64'h0, RNONE, RNONE, RNONE, RNONE, 4'h0};
  localparam logic [M_W-1:0] M_BUBBLE = {STAT_AOK, ICODE_NOP, 1'b0, 64'h0, 64'h0,
                                         RNONE, RNONE};
  localparam logic [W_W-1:0] W_BUBBLE = {STAT_AOK, ICODE_NOP, 64'h0, 64'h0,
                                         RNONE, RNONE};

  logic [PC_W-1:0]  f_q;
  logic [D_W-1:0]   d_q;
  logic [E_W-1:0]   e_q;
  logic [M_W-1:0]   m_q;
  logic [W_W-1:0]   w_q;
  logic [CC_W-1:0]  cc_q;
  logic             err_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] retire_q;

  logic halted_c;
  logic retire_c;

  // Anything other than AOK sitting in W freezes the machine until reset.
  assign halted_c = (w_q[W_W-1 -: 4] != STAT_AOK);
  assign retire_c = !halted_c && !bus.W_stall &&
                    (bus.w_in[W_W-1 -: 4] == STAT_AOK) &&
                    (bus.w_in[W_W-5 -: 4] != ICODE_NOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= '0;
      d_q <= D_BUBBLE;
      e_q <= E_BUBBLE;
      m_q <= M_BUBBLE;
      w_q <= W_BUBBLE;
    end else if (!halted_c) begin
      if (!bus.F_stall) f_q <= bus.f_predPC;
      // Stall takes priority over bubble on D.
      if (!bus.D_stall) d_q <= bus.D_bubble ? D_BUBBLE : bus.d_in;
      e_q <= bus.E_bubble ? E_BUBBLE : bus.e_in;
      m_q <= bus.M_bubble ? M_BUBBLE : bus.m_in;
      if (!bus.W_stall) w_q <= bus.w_in;
    end
  end

  // Condition codes and the sticky D-control conflict flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q  <= CC_RESET;
      err_q <= 1'b0;
    end else if (!halted_c) begin
      if (bus.set_cc) cc_q <= bus.cc_in;
      if (bus.D_stall && bus.D_bubble) err_q <= 1'b1;
    end
  end

  // Performance counters, both wrap modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      if (!halted_c) cycle_q <= cycle_q + CNT_W'(1);
      if (retire_c)  retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign bus.F_predPC   = f_q;
  assign bus.D_out      = d_q;
  assign bus.E_out      = e_q;
  assign bus.M_out      = m_q;
  assign bus.W_out      = w_q;
  assign bus.cc         = cc_q;
  assign bus.ctrl_err   = err_q;
  assign bus.cycle_cnt  = cycle_q;
  assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_pipe_regs.sv
// Directed self-checking bench for pipe_regs.
module tb_pipe_regs;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pipe_regs_if bus ();

  pipe_regs dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [147:0] mk_d(input logic [3:0] stat, input logic [3:0] icode,
                                        input logic [3:0] ifun, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [63:0] valc,
                                        input logic [63:0] valp);
    return {stat, icode, ifun, ra, rb, valc, valp};
  endfunction

  function automatic logic [223:0] mk_e(input logic [3:0] stat, input logic [3:0] icode,
                                        input logic [3:0] ifun, input logic [63:0] valc,
                                        input logic [63:0] vala, input logic [63:0] valb,
                                        input logic [3:0] dste, input logic [3:0] dstm,
                                        input logic [3:0] srca, input logic [3:0] srcb);
    return {stat, icode, ifun, valc, vala, valb, dste, dstm, srca, srcb, 4'h0};
  endfunction

  function automatic logic [144:0] mk_m(input logic [3:0] stat, input logic [3:0] icode,
                                        input logic cnd, input logic [63:0] vale,
                                        input logic [63:0] vala, input logic [3:0] dste,
                                        input logic [3:0] dstm);
    return {stat, icode, cnd, vale, vala, dste, dstm};
  endfunction

  function automatic logic [143:0] mk_w(input logic [3:0] stat, input logic [3:0] icode,
                                        input logic [63:0] vale, input logic [63:0] valm,
                                        input logic [3:0] dste, input logic [3:0] dstm);
    return {stat, icode, vale, valm, dste, dstm};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [147:0] d_bub, d1, dh;
  logic [223:0] e_bub, eh;
  logic [144:0] m_bub, mh;
  logic [143:0] w_bub, w_nop, w_ret, w_hlt;

  task automatic check_reset_state(input string tag);
    check({tag, "_f"},      256'(bus.F_predPC), 256'(0));
    check({tag, "_d"},      256'(bus.D_out), 256'(d_bub));
    check({tag, "_e"},      256'(bus.E_out), 256'(e_bub));
    check({tag, "_m"},      256'(bus.M_out), 256'(m_bub));
    check({tag, "_w"},      256'(bus.W_out), 256'(w_bub));
    check({tag, "_cc"},     256'(bus.cc), 256'(3'b100));
    check({tag, "_err"},    256'(bus.ctrl_err), 256'(0));
    check({tag, "_cyc"},    256'(bus.cycle_cnt), 256'(0));
    check({tag, "_ret"},    256'(bus.retire_cnt), 256'(0));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    d_bub = mk_d(4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    e_bub = mk_e(4'h1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    m_bub = mk_m(4'h1, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF);
    w_bub = mk_w(4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    w_nop = mk_w(4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    w_ret = mk_w(4'h1, 4'h6, 64'h5, 64'h0, 4'h2, 4'hF);
    w_hlt = mk_w(4'h2, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    d1    = mk_d(4'h1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h10, 64'h20);

    rst = 1'b1;
    bus.F_stall = 1'b0; bus.D_stall = 1'b0; bus.D_bubble = 1'b0;
    bus.E_bubble = 1'b0; bus.M_bubble = 1'b0; bus.W_stall = 1'b0;
    bus.set_cc = 1'b0; bus.cc_in = 3'b000;
    bus.f_predPC = 64'h0;
    bus.d_in = d_bub; bus.e_in = e_bub;
    bus.m_in = mk_m(4'h1, 4'h3, 1'b1, 64'h77, 64'h88, 4'h4, 4'h5);
    bus.w_in = w_nop;
    step();
    check_reset_state("rst");

    // Fetch/decode path, one cycle per stage
    rst = 1'b0;
    bus.f_predPC = 64'h100;
    bus.d_in = d1;
    step();
    check("d_icode", 256'(bus.D_out[143:140]), 256'(4'h6));
    check("d_valc",  256'(bus.D_out[127:64]), 256'(64'h10));
    check("f_load",  256'(bus.F_predPC), 256'(64'h100));
    check("cyc1",    256'(bus.cycle_cnt), 256'(1));
    bus.e_in = mk_e(bus.D_out[147:144], bus.D_out[143:140], bus.D_out[139:136],
                    bus.D_out[127:64], 64'h0, 64'h0, 4'h2, 4'hF, 4'h3, 4'hF);
    step();
    check("e_icode", 256'(bus.E_out[219:216]), 256'(4'h6));
    check("m_load",  256'(bus.M_out), 256'(mk_m(4'h1, 4'h3, 1'b1, 64'h77, 64'h88, 4'h4, 4'h5)));
    bus.w_in = w_ret;
    step();
    check("w_load",  256'(bus.W_out), 256'(w_ret));
    check("ret1",    256'(bus.retire_cnt), 256'(1));
    bus.w_in = w_nop;

    // Stall F/D for two cycles with changing inputs, bubble E
    bus.F_stall = 1'b1; bus.D_stall = 1'b1; bus.E_bubble = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.f_predPC = 64'h200 + 64'(i);
      bus.d_in = mk_d(4'h1, 4'h9, 4'h1, 4'h4, 4'h5, 64'(i), 64'h30);
      step();
      check("stall_f",   256'(bus.F_predPC), 256'(64'h100));
      check("stall_d",   256'(bus.D_out), 256'(d1));
      check("ebub_icode", 256'(bus.E_out[219:216]), 256'(4'h1));
      check("ebub_dste", 256'(bus.E_out[19:16]), 256'(4'hF));
    end
    check("ret_nop", 256'(bus.retire_cnt), 256'(1));
    bus.F_stall = 1'b0; bus.D_stall = 1'b0; bus.E_bubble = 1'b0;

    // D bubble, then stall+bubble conflict
    bus.D_bubble = 1'b1;
    bus.d_in = mk_d(4'h1, 4'h7, 4'h0, 4'h1, 4'h2, 64'h40, 64'h50);
    step();
    check("dbub_icode", 256'(bus.D_out[143:140]), 256'(4'h1));
    check("dbub_ra",    256'(bus.D_out[135:132]), 256'(4'hF));
    check("dbub_rb",    256'(bus.D_out[131:128]), 256'(4'hF));
    check("err0",       256'(bus.ctrl_err), 256'(0));
    bus.D_stall = 1'b1;
    bus.d_in = mk_d(4'h1, 4'h8, 4'h0, 4'h1, 4'h2, 64'h60, 64'h70);
    step();
    check("conf_hold", 256'(bus.D_out), 256'(d_bub));
    check("err1",      256'(bus.ctrl_err), 256'(1));
    bus.D_stall = 1'b0; bus.D_bubble = 1'b0;
    step();
    check("err_sticky", 256'(bus.ctrl_err), 256'(1));
    check("d_resume",   256'(bus.D_out), 256'(mk_d(4'h1, 4'h8, 4'h0, 4'h1, 4'h2, 64'h60, 64'h70)));

    // Condition codes
    bus.set_cc = 1'b1; bus.cc_in = 3'b011;
    step();
    check("cc_set", 256'(bus.cc), 256'(3'b011));
    bus.set_cc = 1'b0; bus.cc_in = 3'b100;
    step();
    check("cc_hold", 256'(bus.cc), 256'(3'b011));
    check("cyc10",   256'(bus.cycle_cnt), 256'(10));

    // Counter wrap: preload the cycle counter one short of rollover
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    bus.f_predPC = 64'h300;
    step();
    check("cyc_wrap",   256'(bus.cycle_cnt), 256'(0));
    check("wrap_ret",   256'(bus.retire_cnt), 256'(1));
    check("wrap_cc",    256'(bus.cc), 256'(3'b011));
    check("wrap_f",     256'(bus.F_predPC), 256'(64'h300));

    // Halt freeze
    dh = mk_d(4'h1, 4'hA, 4'h2, 4'h6, 4'h7, 64'hAA, 64'hBB);
    eh = mk_e(4'h1, 4'hB, 4'h0, 64'h1, 64'h2, 64'h3, 4'h1, 4'h2, 4'h3, 4'h4);
    mh = mk_m(4'h1, 4'hC, 1'b1, 64'h4, 64'h5, 4'h6, 4'h7);
    bus.f_predPC = 64'h400; bus.d_in = dh; bus.e_in = eh; bus.m_in = mh;
    bus.w_in = w_hlt;
    step();
    check("hlt_stat", 256'(bus.W_out[143:140]), 256'(4'h2));
    check("hlt_cyc",  256'(bus.cycle_cnt), 256'(1));
    bus.f_predPC = 64'h500;
    bus.d_in = d1; bus.e_in = e_bub; bus.m_in = m_bub; bus.w_in = w_ret;
    bus.set_cc = 1'b1; bus.cc_in = 3'b101; bus.E_bubble = 1'b1; bus.M_bubble = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("frz_f",   256'(bus.F_predPC), 256'(64'h400));
      check("frz_d",   256'(bus.D_out), 256'(dh));
      check("frz_e",   256'(bus.E_out), 256'(eh));
      check("frz_m",   256'(bus.M_out), 256'(mh));
      check("frz_w",   256'(bus.W_out), 256'(w_hlt));
      check("frz_cc",  256'(bus.cc), 256'(3'b011));
      check("frz_cyc", 256'(bus.cycle_cnt), 256'(1));
      check("frz_ret", 256'(bus.retire_cnt), 256'(1));
    end

    // Reset out of halt, then normal loading resumes
    rst = 1'b1;
    step();
    check_reset_state("rst2");
    rst = 1'b0;
    bus.set_cc = 1'b0; bus.E_bubble = 1'b0; bus.M_bubble = 1'b0;
    bus.e_in = eh; bus.m_in = mh;
    step();
    check("post_f",   256'(bus.F_predPC), 256'(64'h500));
    check("post_d",   256'(bus.D_out), 256'(d1));
    check("post_e",   256'(bus.E_out), 256'(eh));
    check("post_w",   256'(bus.W_out), 256'(w_ret));
    check("post_ret", 256'(bus.retire_cnt), 256'(1));
    check("post_cyc", 256'(bus.cycle_cnt), 256'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
